// File: rtl/serial_rx_controller.sv
// Control FSM for an asynchronous serial receiver built around an external 8-bit right-shift register.
// Times bit centres, strobes one shift per data bit, checks the stop bit and offers the byte over Valid/Ack.
module serial_rx_controller #(
    parameter int BIT_CYCLES = 8
) (
    input  logic       Clk,
    input  logic       RS,
    input  logic       SIn,
    input  logic [7:0] Q,
    output logic       SID,
    output logic       ShEn,
    output logic       SRClr,
    output logic [7:0] Data,
    output logic       Valid,
    input  logic       Ack,
    output logic       FrmErr,
    output logic       Overrun,
    output logic       Busy
);

    localparam int HALF = BIT_CYCLES / 2;
    localparam int CW   = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] LAST      = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} stateT;

    stateT         state, stateNext;
    logic [CW-1:0] cnt, cntNext;
    logic [2:0]    bitIdx, bitIdxNext;
    logic          shift, byteDone, stopErr;

    // State, counters and the consumer-facing byte buffer; a byte landing on an Ack edge wins over the clear
    always_ff @(posedge Clk) begin
        if (RS) begin
            state   <= IDLE;
            cnt     <= '0;
            bitIdx  <= '0;
            Data    <= '0;
            Valid   <= 1'b0;
            Overrun <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            bitIdx <= bitIdxNext;
            if (byteDone) begin
                Data  <= Q;
                Valid <= 1'b1;
                if (Valid && !Ack) begin
                    Overrun <= 1'b1;
                end else if (Valid && Ack) begin
                    Overrun <= 1'b0;
                end
            end else if (Valid && Ack) begin
                Valid   <= 1'b0;
                Overrun <= 1'b0;
            end
        end
    end

    // Next-state logic; START waits half a bit so every later sample lands at a bit centre
    always_comb begin
        stateNext  = state;
        cntNext    = cnt;
        bitIdxNext = bitIdx;
        shift      = 1'b0;
        byteDone   = 1'b0;
        stopErr    = 1'b0;
        case (state)
            IDLE: begin
                if (!SIn) begin
                    stateNext = START;
                    cntNext   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cntNext = '0;
                    if (!SIn) begin
                        stateNext  = DATA;
                        bitIdxNext = '0;
                    end else begin
                        stateNext = IDLE;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    shift   = 1'b1;
                    cntNext = '0;
                    if (bitIdx == 3'd7) begin
                        stateNext = STOP;
                    end else begin
                        bitIdxNext = bitIdx + 3'd1;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cntNext   = '0;
                    stateNext = IDLE;
                    if (SIn) begin
                        byteDone = 1'b1;
                    end else begin
                        stopErr = 1'b1;
                    end
                end else begin
                    cntNext = cnt + 1'b1;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // Strobes are suppressed during reset so an aborted frame cannot shift or flag
    assign SID    = SIn;
    assign ShEn   = shift & ~RS;
    assign FrmErr = stopErr & ~RS;
    assign SRClr  = RS | ((state == IDLE) & ~SIn);
    assign Busy   = (state != IDLE);

endmodule

// File: tb/tb_serial_rx_controller.sv
// Bench for serial_rx_controller with a behavioural shift register; stimulus queues expected
// byte/error events and a negedge monitor pops and compares them as the DUT presents them.
module tb_serial_rx_controller;

    logic       Clk = 1'b0;
    logic       RS, SIn, Ack;
    logic [7:0] Q;
    logic       SID, ShEn, SRClr, Valid, FrmErr, Overrun, Busy;
    logic [7:0] Data;

    typedef struct {
        bit         isErr;
        logic [7:0] data;
        bit         ov;
        int         expCyc;
    } expT;

    expT  sb[$];
    int   shQ[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    int   lastStart = 0;
    expT  ev;
    logic prevValid = 1'b0;
    logic prevFrmErr = 1'b0;
    logic [7:0] prevData = 8'h00;

    serial_rx_controller #(.BIT_CYCLES(8)) dut (
        .Clk(Clk), .RS(RS), .SIn(SIn), .Q(Q), .SID(SID), .ShEn(ShEn), .SRClr(SRClr),
        .Data(Data), .Valid(Valid), .Ack(Ack), .FrmErr(FrmErr), .Overrun(Overrun), .Busy(Busy)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // External right-shift register: new bit enters at the top, first bit ends up in Q[0]
    always @(posedge Clk) begin
        if (SRClr) Q <= 8'h00;
        else if (ShEn) Q <= {SID, Q[7:1]};
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: a byte event is Valid rising or Data changing while Valid stays high
    always @(negedge Clk) begin
        #2;
        if (!RS) begin
            if (ShEn) shQ.push_back(cyc);
            if (FrmErr && prevFrmErr) checkOutput("frmErrWidth", 2, 1);
            if ((FrmErr && !prevFrmErr) || (Valid && (!prevValid || Data != prevData))) begin
                if (sb.size() == 0) begin
                    checkOutput("unexpectedEvent", 1, 0);
                end else begin
                    ev = sb.pop_front();
                    checkOutput("evKind", int'(FrmErr), int'(ev.isErr));
                    checkOutput("evCycle", cyc, ev.expCyc);
                    if (!ev.isErr) begin
                        checkOutput("evData", int'(Data), int'(ev.data));
                        checkOutput("evOverrun", int'(Overrun), int'(ev.ov));
                    end
                end
            end
        end
        prevValid  = Valid;
        prevData   = Data;
        prevFrmErr = FrmErr;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge Clk);
            SIn = 1'b1;
            Ack = 1'b0;
        end
    endtask

    task automatic ackPulse();
        @(negedge Clk);
        Ack = 1'b1;
        @(negedge Clk);
        Ack = 1'b0;
        #2;
        checkOutput("validAfterAck", int'(Valid), 0);
        checkOutput("overrunAfterAck", int'(Overrun), 0);
    endtask

    // One 80-cycle frame; optional Ack on the completing edge, optional reset at cycle rsAt
    task automatic applyStimulus(input logic [7:0] d, input logic stopBit, input bit expOv,
                                 input bit ackStop, input int rsAt);
        for (int c = 0; c < 80; c++) begin
            @(negedge Clk);
            if (c == 0) begin
                lastStart = cyc;
                if (rsAt < 0) begin
                    if (stopBit) sb.push_back('{1'b0, d, expOv, cyc + 77});
                    else sb.push_back('{1'b1, d, 1'b0, cyc + 76});
                end
            end
            if (rsAt >= 0 && c == rsAt + 1) begin
                RS  = 1'b0;
                SIn = 1'b1;
                #2;
                checkOutput("busyAfterRs", int'(Busy), 0);
                checkOutput("validAfterRs", int'(Valid), 0);
                checkOutput("dataAfterRs", int'(Data), 0);
                checkOutput("overrunAfterRs", int'(Overrun), 0);
                break;
            end
            if (c < 8) SIn = 1'b0;
            else if (c >= 72) SIn = stopBit;
            else SIn = d[c/8-1];
            Ack = (ackStop && c == 76);
            if (c == rsAt) begin
                RS = 1'b1;
                #2;
                checkOutput("srClrInRs", int'(SRClr), 1);
                checkOutput("shEnInRs", int'(ShEn), 0);
            end
        end
    endtask

    initial begin
        RS  = 1'b1;
        SIn = 1'b1;
        Ack = 1'b0;
        repeat (2) @(negedge Clk);
        #2;
        checkOutput("rstSrClr", int'(SRClr), 1);
        checkOutput("rstValid", int'(Valid), 0);
        checkOutput("rstBusy", int'(Busy), 0);
        checkOutput("rstData", int'(Data), 0);
        checkOutput("rstOverrun", int'(Overrun), 0);
        checkOutput("rstFrmErr", int'(FrmErr), 0);
        @(negedge Clk);
        RS = 1'b0;
        idle(4);

        // Plain frame: latency, exact shift spacing, then Ack
        applyStimulus(8'hA5, 1'b1, 1'b0, 1'b0, -1);
        checkOutput("a5ShEnCount", shQ.size(), 8);
        for (int i = 0; i < 8; i++)
            checkOutput("a5ShEnCycle", (i < shQ.size()) ? shQ[i] : -1, lastStart + 12 + 8*i);
        shQ.delete();
        ackPulse();

        // False start: line drops for two cycles only
        idle(4);
        @(negedge Clk); SIn = 1'b0;
        @(negedge Clk); SIn = 1'b0;
        #2;
        checkOutput("falseStartBusy", int'(Busy), 1);
        idle(20);
        checkOutput("falseStartIdle", int'(Busy), 0);
        checkOutput("falseStartShEn", shQ.size(), 0);
        checkOutput("falseStartValid", int'(Valid), 0);

        // Bad stop bit: error pulse only, buffered byte untouched
        applyStimulus(8'h3C, 1'b0, 1'b0, 1'b0, -1);
        idle(20);
        checkOutput("ferrShEnCount", shQ.size(), 8);
        shQ.delete();
        checkOutput("ferrValid", int'(Valid), 0);
        checkOutput("ferrData", int'(Data), 8'hA5);
        checkOutput("ferrBusy", int'(Busy), 0);

        // Back-to-back without Ack sets Overrun
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, -1);
        applyStimulus(8'h22, 1'b1, 1'b1, 1'b0, -1);
        checkOutput("b2bShEnCount", shQ.size(), 16);
        shQ.delete();
        ackPulse();

        // Ack coinciding with a new byte: byte replaces, no Overrun
        idle(5);
        applyStimulus(8'h11, 1'b1, 1'b0, 1'b0, -1);
        idle(5);
        applyStimulus(8'h55, 1'b1, 1'b0, 1'b1, -1);
        idle(3);
        checkOutput("ackEdgeValid", int'(Valid), 1);
        checkOutput("ackEdgeData", int'(Data), 8'h55);
        checkOutput("ackEdgeOverrun", int'(Overrun), 0);
        shQ.delete();

        // Reset during data bit 4 with 0x55 still held, then a clean frame
        idle(5);
        applyStimulus(8'h0F, 1'b1, 1'b0, 1'b0, 42);
        checkOutput("rsShEnCount", shQ.size(), 4);
        shQ.delete();
        idle(10);
        applyStimulus(8'hF0, 1'b1, 1'b0, 1'b0, -1);
        idle(3);
        checkOutput("f0Data", int'(Data), 8'hF0);
        ackPulse();

        idle(10);
        checkOutput("scoreboardEmpty", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
